// File: rtl/writeback_queue.sv
// Multi-lane writeback queue between EX and the register file: in-order circular
// buffer with compacted multi-lane enqueue, multi-port drain and a bypass lookup.

module writeback_queue_lane #(
  parameter int W_RD = 5
) (
  input  logic            v,
  input  logic            wb,
  input  logic [W_RD-1:0] rd_num,
  output logic            take
);
  assign take = v & wb & (rd_num != '0);
endmodule

module writeback_queue #(
  parameter int WORD  = 32,
  parameter int W_RD  = 5,
  parameter int NLANE = 2,
  parameter int NPORT = 1,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NLANE-1:0]      v_i,
  input  logic [NLANE-1:0]      wb_i,
  input  logic [NLANE*W_RD-1:0] rd_num_i,
  input  logic [NLANE*WORD-1:0] rd_data_i,
  output logic                  stall_o,
  output logic [NPORT-1:0]      wb_o,
  output logic [NPORT*W_RD-1:0] wbr_num_o,
  output logic [NPORT*WORD-1:0] wb_data_o,
  input  logic [W_RD-1:0]       q_num_i,
  output logic                  q_hit_o,
  output logic [WORD-1:0]       q_data_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W_RD-1:0] num_q  [DEPTH];
  logic [WORD-1:0] data_q [DEPTH];
  logic [PW-1:0]   head_q, tail_q;
  logic [CW-1:0]   count_q;

  logic [NLANE-1:0][W_RD-1:0] lane_num;
  logic [NLANE-1:0][WORD-1:0] lane_data;
  logic [NLANE-1:0]           take;
  logic [NLANE-1:0][PW-1:0]   slot;
  int                         acc;

  logic [NPORT-1:0]           pres, en;
  logic [NPORT-1:0][W_RD-1:0] p_num, o_num;
  logic [NPORT-1:0][WORD-1:0] p_data, o_data;
  int                         n_drain;

  assign lane_num  = rd_num_i;
  assign lane_data = rd_data_i;

  for (genvar k = 0; k < NLANE; k++) begin : g_lane
    writeback_queue_lane #(.W_RD(W_RD)) u_lane (
      .v      (v_i[k]),
      .wb     (wb_i[k]),
      .rd_num (lane_num[k]),
      .take   (take[k])
    );
  end

  // Stall depends only on registered count, so it never loops back through v_i.
  assign stall_o = (DEPTH - int'(count_q)) < NLANE;

  always_comb begin
    acc = 0;
    for (int k = 0; k < NLANE; k++) begin
      slot[k] = PW'((int'(tail_q) + acc) % DEPTH);
      if (take[k] && !stall_o) acc = acc + 1;
    end
  end

  always_comb begin
    n_drain = 0;
    for (int p = 0; p < NPORT; p++) begin
      pres[p]   = p < int'(count_q);
      p_num[p]  = num_q[PW'((int'(head_q) + p) % DEPTH)];
      p_data[p] = data_q[PW'((int'(head_q) + p) % DEPTH)];
      if (pres[p]) n_drain = n_drain + 1;
    end
    // An older presented entry is suppressed if a younger one targets the same register.
    for (int p = 0; p < NPORT; p++) begin
      en[p] = pres[p];
      for (int q = p + 1; q < NPORT; q++)
        if (pres[q] && p_num[q] == p_num[p]) en[p] = 1'b0;
      o_num[p]  = en[p] ? p_num[p]  : '0;
      o_data[p] = en[p] ? p_data[p] : '0;
    end
  end

  assign wb_o      = en;
  assign wbr_num_o = o_num;
  assign wb_data_o = o_data;

  always_comb begin
    q_hit_o  = 1'b0;
    q_data_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i < int'(count_q) && q_num_i != '0 &&
          num_q[PW'((int'(head_q) + i) % DEPTH)] == q_num_i) begin
        q_hit_o  = 1'b1;
        q_data_o = data_q[PW'((int'(head_q) + i) % DEPTH)];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= PW'((int'(head_q) + n_drain) % DEPTH);
      tail_q  <= PW'((int'(tail_q) + acc) % DEPTH);
      count_q <= CW'(int'(count_q) - n_drain + acc);
    end
  end

  // Accepted slots are always free, so writes never collide with entries being drained.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NLANE; k++) begin
      if (take[k] && !stall_o) begin
        num_q[slot[k]]  <= lane_num[k];
        data_q[slot[k]] <= lane_data[k];
      end
    end
  end
endmodule

// File: tb/tb_writeback_queue.sv
// Scoreboard bench for writeback_queue: one instance with a single write port,
// one with two write ports for same-cycle collision checks.

module tb_writeback_queue;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  n;
    logic [31:0] d;
  } wr_t;

  wr_t exp1[$];
  wr_t exp2[$];
  int  total = 0;
  int  bad   = 0;
  bit  mon_en = 1'b0;

  logic [1:0]  v1 = '0, wb1 = '0;
  logic [9:0]  rn1 = '0;
  logic [63:0] rd1 = '0;
  logic        st1, qh1;
  logic [0:0]  wo1;
  logic [4:0]  on1;
  logic [31:0] od1, qd1;
  logic [4:0]  qn1 = '0;

  logic [1:0]  v2 = '0, wb2 = '0;
  logic [9:0]  rn2 = '0;
  logic [63:0] rd2 = '0;
  logic        st2, qh2;
  logic [1:0]  wo2;
  logic [9:0]  on2;
  logic [63:0] od2;
  logic [31:0] qd2;
  logic [4:0]  qn2 = '0;

  writeback_queue #(.WORD(32), .W_RD(5), .NLANE(2), .NPORT(1), .DEPTH(4)) u1 (
    .clk(clk), .rst(rst), .v_i(v1), .wb_i(wb1), .rd_num_i(rn1), .rd_data_i(rd1),
    .stall_o(st1), .wb_o(wo1), .wbr_num_o(on1), .wb_data_o(od1),
    .q_num_i(qn1), .q_hit_o(qh1), .q_data_o(qd1));

  writeback_queue #(.WORD(32), .W_RD(5), .NLANE(2), .NPORT(2), .DEPTH(4)) u2 (
    .clk(clk), .rst(rst), .v_i(v2), .wb_i(wb2), .rd_num_i(rn2), .rd_data_i(rd2),
    .stall_o(st2), .wb_o(wo2), .wbr_num_o(on2), .wb_data_o(od2),
    .q_num_i(qn2), .q_hit_o(qh2), .q_data_o(qd2));

  function automatic wr_t mk(input logic [4:0] n, input logic [31:0] d);
    wr_t w;
    w.n = n;
    w.d = d;
    return w;
  endfunction

  task automatic set1(input logic [1:0] v, input logic [1:0] wb, input logic [4:0] n0,
                      input logic [31:0] d0, input logic [4:0] n1, input logic [31:0] d1);
    v1 = v; wb1 = wb; rn1 = {n1, n0}; rd1 = {d1, d0};
  endtask

  task automatic set2(input logic [1:0] v, input logic [1:0] wb, input logic [4:0] n0,
                      input logic [31:0] d0, input logic [4:0] n1, input logic [31:0] d1);
    v2 = v; wb2 = wb; rn2 = {n1, n0}; rd2 = {d1, d0};
  endtask

  // Monitors: every enabled port must match the oldest outstanding expectation; idle ports must be zero.
  always @(negedge clk) begin : mon1
    wr_t e;
    if (mon_en) begin
      total++;
      if (wo1 === 1'b1) begin
        if (exp1.size() == 0) begin
          bad++; $display("FAIL mon1 unexpected write r%0d=%h", on1, od1);
        end else begin
          e = exp1.pop_front();
          if (on1 !== e.n || od1 !== e.d) begin
            bad++; $display("FAIL mon1 got r%0d=%h want r%0d=%h", on1, od1, e.n, e.d);
          end
        end
      end else if (wo1 !== 1'b0 || on1 !== '0 || od1 !== '0) begin
        bad++; $display("FAIL mon1_idle wb=%b num=%0d data=%h want all 0", wo1, on1, od1);
      end
    end
  end

  always @(negedge clk) begin : mon2
    wr_t e;
    if (mon_en) begin
      for (int p = 0; p < 2; p++) begin
        total++;
        if (wo2[p] === 1'b1) begin
          if (exp2.size() == 0) begin
            bad++; $display("FAIL mon2 port%0d unexpected write r%0d", p, on2[p*5 +: 5]);
          end else begin
            e = exp2.pop_front();
            if (on2[p*5 +: 5] !== e.n || od2[p*32 +: 32] !== e.d) begin
              bad++; $display("FAIL mon2 port%0d got r%0d=%h want r%0d=%h", p,
                              on2[p*5 +: 5], od2[p*32 +: 32], e.n, e.d);
            end
          end
        end else if (wo2[p] !== 1'b0 || on2[p*5 +: 5] !== '0 || od2[p*32 +: 32] !== '0) begin
          bad++; $display("FAIL mon2_idle port%0d wb=%b num=%0d data=%h want 0", p, wo2[p],
                          on2[p*5 +: 5], od2[p*32 +: 32]);
        end
      end
    end
  end

  task automatic test_reset;
    mon_en = 1'b0;
    rst = 1'b0;
    #12;
    total++;
    if (wo1 !== 1'b0 || st1 !== 1'b0 || on1 !== '0 || od1 !== '0 || qh1 !== 1'b0 || qd1 !== '0) begin
      bad++; $display("FAIL reset_outs wb=%b stall=%b num=%0d data=%h hit=%b want all 0",
                      wo1, st1, on1, od1, qh1);
    end
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1 set1(2'b11, 2'b11, 5'd1, 32'h11, 5'd2, 32'h22);
    @(posedge clk); #1 set1(2'b11, 2'b11, 5'd3, 32'h33, 5'd4, 32'h44);
    @(posedge clk); #1 set1(2'b00, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    qn1 = 5'd3;
    total++;
    if (st1 !== 1'b1) begin bad++; $display("FAIL pre_reset_stall got %b want 1", st1); end
    rst = 1'b0;
    #1;
    total++;
    if (wo1 !== 1'b0 || st1 !== 1'b0 || qh1 !== 1'b0) begin
      bad++; $display("FAIL reset_async wb=%b stall=%b hit=%b want 0 0 0", wo1, st1, qh1);
    end
    qn1 = 5'd0;
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (wo1 !== 1'b0) begin bad++; $display("FAIL no_stale cycle%0d wb=%b want 0", i, wo1); end
    end
    mon_en = 1'b1;
  endtask

  task automatic test_single;
    @(posedge clk); #1 set1(2'b01, 2'b01, 5'd5, 32'hDEAD, 5'd0, 32'h0);
    exp1.push_back(mk(5'd5, 32'hDEAD));
    @(negedge clk);
    total++;
    if (wo1 !== 1'b0) begin bad++; $display("FAIL single_early wb=%b want 0", wo1); end
    @(posedge clk); #1 set1(2'b00, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    @(negedge clk);
    total++;
    if (wo1 !== 1'b1 || on1 !== 5'd5 || od1 !== 32'hDEAD) begin
      bad++; $display("FAIL single wb=%b r%0d=%h want 1 r5=dead", wo1, on1, od1);
    end
    @(negedge clk);
    total++;
    if (wo1 !== 1'b0) begin bad++; $display("FAIL single_once wb=%b want 0", wo1); end
  endtask

  task automatic test_fill;
    int  mcount = 0;
    int  nxt = 1;
    int  cyc = 0;
    bit  mstall;
    bit  seen = 1'b0;
    @(posedge clk); #1;
    while (nxt <= 8 && cyc < 40) begin
      mstall = (4 - mcount) < 2;
      total++;
      if (st1 !== mstall) begin
        bad++; $display("FAIL fill_stall cyc%0d got %b want %b (count %0d)", cyc, st1, mstall, mcount);
      end
      if (st1 === 1'b1) seen = 1'b1;
      set1(2'b11, 2'b11, 5'(nxt), 32'h100 + nxt, 5'(nxt + 1), 32'h101 + nxt);
      mcount = mcount - ((mcount > 0) ? 1 : 0);
      if (!mstall) begin
        exp1.push_back(mk(5'(nxt), 32'h100 + nxt));
        exp1.push_back(mk(5'(nxt + 1), 32'h101 + nxt));
        nxt = nxt + 2;
        mcount = mcount + 2;
      end
      cyc++;
      @(posedge clk); #1;
    end
    set1(2'b00, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    total++;
    if (!seen || nxt <= 8) begin
      bad++; $display("FAIL fill_progress seen_stall=%b next=%0d want 1 and 9", seen, nxt);
    end
    repeat (6) @(posedge clk);
    @(negedge clk);
    total++;
    if (exp1.size() != 0) begin bad++; $display("FAIL fill_drain left=%0d want 0", exp1.size()); end
  endtask

  task automatic test_filter;
    @(posedge clk); #1 set1(2'b11, 2'b11, 5'd0, 32'hBAD0, 5'd7, 32'h11);
    exp1.push_back(mk(5'd7, 32'h11));
    @(posedge clk); #1 set1(2'b00, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    @(negedge clk);
    total++;
    if (wo1 !== 1'b1 || on1 !== 5'd7 || od1 !== 32'h11) begin
      bad++; $display("FAIL filter_r7 wb=%b r%0d=%h want 1 r7=11", wo1, on1, od1);
    end
    @(negedge clk);
    total++;
    if (wo1 !== 1'b0) begin bad++; $display("FAIL filter_one_entry wb=%b want 0", wo1); end
    @(posedge clk); #1 set1(2'b01, 2'b10, 5'd6, 32'h66, 5'd6, 32'h67);
    @(posedge clk); #1 set1(2'b00, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    @(negedge clk);
    total++;
    if (wo1 !== 1'b0) begin bad++; $display("FAIL filter_none wb=%b want 0", wo1); end
  endtask

  task automatic test_collision;
    @(posedge clk); #1 set2(2'b11, 2'b11, 5'd3, 32'hA, 5'd3, 32'hB);
    exp2.push_back(mk(5'd3, 32'hB));
    @(posedge clk); #1 set2(2'b00, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    @(negedge clk);
    total++;
    if (wo2 !== 2'b10 || on2 !== {5'd3, 5'd0} || od2 !== {32'hB, 32'h0}) begin
      bad++; $display("FAIL collision wb=%b num=%h data=%h want 10 r3=b on port1", wo2, on2, od2);
    end
    @(negedge clk);
    total++;
    if (wo2 !== 2'b00) begin bad++; $display("FAIL collision_retired wb=%b want 00", wo2); end
    @(posedge clk); #1 set2(2'b11, 2'b11, 5'd1, 32'h1, 5'd2, 32'h2);
    exp2.push_back(mk(5'd1, 32'h1));
    exp2.push_back(mk(5'd2, 32'h2));
    @(posedge clk); #1 set2(2'b00, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    @(negedge clk);
    total++;
    if (wo2 !== 2'b11 || on2 !== {5'd2, 5'd1}) begin
      bad++; $display("FAIL dual_port wb=%b num=%h want 11 r2,r1", wo2, on2);
    end
  endtask

  task automatic test_bypass;
    @(posedge clk); #1 set1(2'b11, 2'b11, 5'd9, 32'h1, 5'd9, 32'h2);
    exp1.push_back(mk(5'd9, 32'h1));
    exp1.push_back(mk(5'd9, 32'h2));
    qn1 = 5'd9; #1;
    total++;
    if (qh1 !== 1'b0) begin bad++; $display("FAIL bypass_not_inputs hit=%b want 0", qh1); end
    @(posedge clk); #1 set1(2'b00, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    #1;
    total++;
    if (qh1 !== 1'b1 || qd1 !== 32'h2) begin
      bad++; $display("FAIL bypass_young hit=%b data=%h want 1 2", qh1, qd1);
    end
    qn1 = 5'd4; #1;
    total++;
    if (qh1 !== 1'b0 || qd1 !== 32'h0) begin
      bad++; $display("FAIL bypass_miss hit=%b data=%h want 0 0", qh1, qd1);
    end
    qn1 = 5'd0; #1;
    total++;
    if (qh1 !== 1'b0 || qd1 !== 32'h0) begin
      bad++; $display("FAIL bypass_x0 hit=%b data=%h want 0 0", qh1, qd1);
    end
    @(posedge clk); #1 qn1 = 5'd9; #1;
    total++;
    if (qh1 !== 1'b1 || qd1 !== 32'h2) begin
      bad++; $display("FAIL bypass_presented hit=%b data=%h want 1 2", qh1, qd1);
    end
    @(posedge clk); #1;
    total++;
    if (qh1 !== 1'b0) begin bad++; $display("FAIL bypass_drained hit=%b want 0", qh1); end
    qn1 = 5'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_single;
    test_fill;
    test_filter;
    test_collision;
    test_bypass;
    repeat (4) @(posedge clk);
    @(negedge clk);
    total++;
    if (exp1.size() != 0 || exp2.size() != 0) begin
      bad++; $display("FAIL scoreboard_left u1=%0d u2=%0d want 0 0", exp1.size(), exp2.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
